mnist_frame_capture: RTL
========================

// Module: mnist_frame_capture
// PURPOSE
// - Consumer end of the display pixel stream: taps the selected 8-bit pixel (grey or sobel lane) in raster order,
//   box-averages a square ROI down to a 28x28 image and writes it into the classifier input RAM.
// - Sits between the camera/display pipeline and the MNIST inference block; one capture per start request.
// PARAMETERS
// - SCALE   8    ROI pixels per output pixel per axis; power of 2 (2..16); ROI side = 28*SCALE
// - ROI_X0  208  first ROI column (centres a 224-wide ROI on 640)
// - ROI_Y0  128  first ROI row (centres a 224-high ROI on 480)
// - INVERT  0    1: wr_data = 255 - average (dark digit on light paper -> MNIST polarity)
// PORTS
// - clk        in   1   pixel clock (single clock domain)
// - rst_n      in   1   asynchronous, active-low reset
// - start      in   1   one-cycle capture request
// - pix_valid  in   1   pix_x/pix_y/pix_data qualify this cycle
// - pix_x      in   10  column of current pixel
// - pix_y      in   10  row of current pixel
// - pix_data   in   8   selected pixel intensity
// - wr_en      out  1   one-cycle write strobe to classifier RAM
// - wr_addr    out  10  0..783, row-major (row*28 + col)
// - wr_data    out  8   averaged (optionally inverted) pixel
// - busy       out  1   high from accepted start until done
// - done       out  1   one-cycle pulse after the last write
// BEHAVIOUR
// - Reset: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, state IDLE, all accumulators 0.
// - SOF = pix_valid & pix_x==0 & pix_y==0. Pixels with pix_valid=0 are ignored in every state.
// - FSM: IDLE --start--> ARMED (busy=1). ARMED --SOF--> CAPTURE (SOF pixel itself processed).
//   CAPTURE --write of addr 783--> DONE. DONE -> IDLE next cycle (done=1 for that one cycle, busy=0 in IDLE).
// - start in ARMED/CAPTURE/DONE ignored; start on the same cycle as SOF in IDLE -> ARMED only, waits for next SOF.
// - In ROI: ROI_X0 <= x < ROI_X0+28*SCALE, same for y. Block col bc=(x-ROI_X0)/SCALE, block row
//   br=(y-ROI_Y0)/SCALE, sub-col sx, sub-row sy = remainders (shift/mask only, no dividers).
// - 28 accumulators, width 8+2*log2(SCALE) (14 for SCALE=8), one per block column; no overflow possible.
// - Each in-ROI valid pixel in CAPTURE: acc[bc] += pix_data.
// - Completion: pixel with sx==SCALE-1 & sy==SCALE-1 -> avg = (acc[bc]+pix_data) >> 2*log2(SCALE) (truncate);
//   next cycle wr_en=1, wr_addr=br*28+bc, wr_data=avg (or 255-avg); acc[bc] cleared same edge.
// - Latency: 1 clk from completing pixel to wr_en. Max one write per SCALE cycles; RAM assumed always ready.
// - wr_addr/wr_data hold last value when wr_en=0.
// - SOF during CAPTURE (truncated frame): accumulators cleared, capture restarts on this frame, busy stays 1,
//   SOF pixel processed as first pixel; no done for the aborted frame.
// - Reset mid-operation: immediate return to reset values; in-flight write lost; needs a new start.
// - Out-of-order or missing rows not detected; result then undefined but FSM still reaches DONE or SOF-restarts.
// STRUCTURE
// - Shared package mnist_pkg: IMG_DIM=28, IMG_PIXELS=784, IMG_ADDR_W=10, PIX_W=8, capture FSM state enum.
// - Sub-module block_accum_bank: 28 x ACC_W register bank, ports (bc, add_en, add_val, clr_en) ->
//   sum_out = acc[bc]+add_val combinationally; top keeps FSM, ROI decode, address/write regs.
// TESTING (SCALE=8, ROI 208..431 x 128..351, 640x480 raster, pix_valid=1 unless stated)
// - Flat 100 everywhere, start, one frame -> 784 writes addr 0..783 in order, all data 100; done 1 clk after last.
// - 255 only at x208..215,y128..135, 0 elsewhere -> addr 0 = 255, addr 1..783 = 0.
// - Checkerboard 0/255 per pixel, INVERT=1 build -> every wr_data = 255-127 = 128.
// - start mid-frame (y=200) -> no writes until next SOF; then full 784-write capture.
// - Random pix_valid gaps (50%) on flat 37 -> same 784 writes of 37; no write on invalid cycles.
// - SOF injected at y=240 during capture -> restart: next write addr 0, total 784 writes after restart;
//   separate run: rst_n low at y=300 -> all outputs 0, IDLE; new start captures normally.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST capture path: classifier image geometry and capture FSM states.
package mnist_pkg;

    localparam int unsigned IMG_DIM    = 28;
    localparam int unsigned IMG_PIXELS = 784;
    localparam int unsigned IMG_ADDR_W = 10;
    localparam int unsigned PIX_W      = 8;
    localparam int unsigned COORD_W    = 10;
    localparam int unsigned BC_W       = 5;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDone
    } cap_state_e;

endpackage

// File: rtl/block_accum_bank.sv
// One accumulator per output column; sums the ROI pixels of the block row currently being scanned.
module block_accum_bank
    import mnist_pkg::*;
#(
    parameter int unsigned ACC_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BC_W-1:0]  bc,
    input  logic             add_en,
    input  logic [PIX_W-1:0] add_val,
    input  logic             clr_en,
    input  logic             clr_all,
    output logic [ACC_W-1:0] sum_out
);

    logic [ACC_W-1:0] acc [IMG_DIM];

    assign sum_out = acc[bc] + ACC_W'(add_val);

    // clr_all restarts a frame; the pixel arriving with it still seeds its own block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < IMG_DIM; i++) begin
                acc[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < IMG_DIM; i++) begin
                if (add_en && (bc == BC_W'(i))) begin
                    if (clr_en) begin
                        acc[i] <= '0;
                    end else if (clr_all) begin
                        acc[i] <= ACC_W'(add_val);
                    end else begin
                        acc[i] <= sum_out;
                    end
                end else if (clr_all) begin
                    acc[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/mnist_frame_capture.sv
// Taps the raster pixel stream, box-averages a square ROI down to 28x28 and writes it to the
// classifier input RAM, one capture per start request.
module mnist_frame_capture
    import mnist_pkg::*;
#(
    parameter int unsigned SCALE  = 8,
    parameter int unsigned ROI_X0 = 208,
    parameter int unsigned ROI_Y0 = 128,
    parameter bit          INVERT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic [COORD_W-1:0]    pix_x,
    input  logic [COORD_W-1:0]    pix_y,
    input  logic [PIX_W-1:0]      pix_data,
    output logic                  wr_en,
    output logic [IMG_ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]      wr_data,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned SH       = $clog2(SCALE);
    localparam int unsigned ACC_W    = PIX_W + 2 * SH;
    localparam int unsigned ROI_SIDE = IMG_DIM * SCALE;
    localparam int unsigned CW1      = COORD_W + 1;

    localparam logic [CW1-1:0] X_LO = CW1'(ROI_X0);
    localparam logic [CW1-1:0] X_HI = CW1'(ROI_X0 + ROI_SIDE);
    localparam logic [CW1-1:0] Y_LO = CW1'(ROI_Y0);
    localparam logic [CW1-1:0] Y_HI = CW1'(ROI_Y0 + ROI_SIDE);

    localparam logic [IMG_ADDR_W-1:0] DIM_A     = IMG_ADDR_W'(IMG_DIM);
    localparam logic [IMG_ADDR_W-1:0] LAST_ADDR = IMG_ADDR_W'(IMG_PIXELS - 1);

    cap_state_e state_q, state_d;

    logic                  wr_en_q;
    logic [IMG_ADDR_W-1:0] wr_addr_q;
    logic [PIX_W-1:0]      wr_data_q;

    logic                  sof;
    logic                  in_roi;
    logic [COORD_W-1:0]    x_off, y_off;
    logic [BC_W-1:0]       bc, br;
    logic [SH-1:0]         sx, sy;
    logic                  active;
    logic                  restart;
    logic                  pix_take;
    logic                  complete;
    logic [ACC_W-1:0]      sum_out;
    logic [PIX_W-1:0]      avg;
    logic [PIX_W-1:0]      out_val;
    logic [IMG_ADDR_W-1:0] blk_addr;

    assign sof = pix_valid && (pix_x == '0) && (pix_y == '0);

    assign in_roi = ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI) &&
                    ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);

    // SCALE is a power of two, so block index and sub-position are plain bit fields.
    assign x_off = pix_x - COORD_W'(ROI_X0);
    assign y_off = pix_y - COORD_W'(ROI_Y0);
    assign bc    = BC_W'(x_off >> SH);
    assign br    = BC_W'(y_off >> SH);
    assign sx    = SH'(x_off);
    assign sy    = SH'(y_off);

    always_comb begin
        state_d = state_q;
        active  = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StArmed;
            end
            StArmed: begin
                if (sof) begin
                    state_d = StCapture;
                    active  = 1'b1;
                    restart = 1'b1;
                end
            end
            StCapture: begin
                if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
                    state_d = StDone;
                end else begin
                    active  = 1'b1;
                    restart = sof;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign pix_take = active && pix_valid && in_roi;
    assign complete = pix_take && (&sx) && (&sy);

    block_accum_bank #(
        .ACC_W (ACC_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .bc      (bc),
        .add_en  (pix_take),
        .add_val (pix_data),
        .clr_en  (complete),
        .clr_all (restart),
        .sum_out (sum_out)
    );

    assign avg      = PIX_W'(sum_out >> (2 * SH));
    // Bitwise complement of an 8-bit value is exactly 255 - value.
    assign out_val  = INVERT ? ~avg : avg;
    assign blk_addr = IMG_ADDR_W'(br) * DIM_A + IMG_ADDR_W'(bc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= complete;
            if (complete) begin
                wr_addr_q <= blk_addr;
                wr_data_q <= out_val;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);

endmodule
